// File: rtl/rx_cond_pkg.sv
// Shared types and helpers for the RX line conditioner: break FSM states,
// glitch counter type and the majority vote used by the input filter.
package rx_cond_pkg;

    typedef enum logic [2:0] {
        POR,
        IDLE,
        COUNT,
        PULSE,
        WAIT_HIGH
    } rx_cond_state_t;

    typedef logic [15:0] glitch_count_t;

    localparam glitch_count_t GLITCH_MAX = 16'hFFFF;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_majority_filter.sv
// Synchroniser plus 3-sample majority filter for the raw RX pin.
// The isolated-sample strobe only exists when RX_COND_GLITCH_COUNT_EN is defined.
module rx_majority_filter
    import rx_cond_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_pin,
    output logic rx_out
`ifdef RX_COND_GLITCH_COUNT_EN
    ,
    output logic glitch_event
`endif
);

    logic [SYNC_STAGES-1:0] sync_reg;
    // win_reg[0] is the newest sample, win_reg[2] the oldest
    logic [2:0]             win_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= '1;
            win_reg  <= '1;
            rx_out   <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx_pin};
            win_reg  <= {win_reg[1:0], sync_reg[SYNC_STAGES-1]};
            rx_out   <= majority3(win_reg[0], win_reg[1], win_reg[2]);
        end
    end

`ifdef RX_COND_GLITCH_COUNT_EN
    assign glitch_event = (win_reg[1] != win_reg[0]) && (win_reg[1] != win_reg[2]);
`endif

endmodule

// File: rtl/rx_line_conditioner.sv
// RX pin front end: filtered line for uart_rx, break detection driving chip_reset.
// Optional glitch counter built only when RX_COND_GLITCH_COUNT_EN is defined.
module rx_line_conditioner
    import rx_cond_pkg::*;
#(
    parameter int          SYNC_STAGES        = 2,
    parameter logic [31:0] BREAK_CYCLES       = 32'd20000,
    parameter logic [31:0] RESET_PULSE_CYCLES = 32'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_pin,
    output logic        rx_out,
    output logic        chip_reset,
    output logic        break_active,
    output logic [15:0] glitch_count
);

    rx_cond_state_t state_reg, state_next;
    logic [31:0]    cnt_reg, cnt_next;
    logic           break_reg, break_next;

`ifdef RX_COND_GLITCH_COUNT_EN
    logic glitch_event;
`endif

    rx_majority_filter #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_filter (
        .clk          (clk),
        .reset        (reset),
        .rx_pin       (rx_pin),
        .rx_out       (rx_out)
`ifdef RX_COND_GLITCH_COUNT_EN
        ,
        .glitch_event (glitch_event)
`endif
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= POR;
            cnt_reg   <= '0;
            break_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            break_reg <= break_next;
        end
    end

    // POR and PULSE share the pulse timer; both hand over to WAIT_HIGH so a
    // held-low line cannot retrigger until it has been seen high.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        break_next = break_reg;
        unique case (state_reg)
            POR, PULSE: begin
                if (cnt_reg == RESET_PULSE_CYCLES - 32'd1) begin
                    state_next = WAIT_HIGH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            IDLE: begin
                if (!rx_out) begin
                    state_next = COUNT;
                    cnt_next   = 32'd1;
                end
            end
            COUNT: begin
                if (rx_out) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == BREAK_CYCLES - 32'd1) begin
                    state_next = PULSE;
                    cnt_next   = '0;
                    break_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            WAIT_HIGH: begin
                if (rx_out) begin
                    state_next = IDLE;
                    break_next = 1'b0;
                end
            end
            default: begin
                state_next = POR;
                cnt_next   = '0;
                break_next = 1'b0;
            end
        endcase
    end

    always_comb begin
        chip_reset = (state_reg == POR) || (state_reg == PULSE);
    end

    assign break_active = break_reg;

`ifdef RX_COND_GLITCH_COUNT_EN
    glitch_count_t gcnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gcnt_reg <= '0;
        end else if (glitch_event && (gcnt_reg != GLITCH_MAX)) begin
            gcnt_reg <= gcnt_reg + 16'd1;
        end
    end

    assign glitch_count = gcnt_reg;
`else
    assign glitch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_rx_line_conditioner.sv
// Self-checking bench for rx_line_conditioner: cycle model of the filter and
// break rules compared every cycle, plus directed literal expectations.
module tb_rx_line_conditioner;

    localparam int S = 2;
    localparam int B = 8;
    localparam int R = 4;
`ifdef RX_COND_GLITCH_COUNT_EN
    localparam int GC_ON = 1;
`else
    localparam int GC_ON = 0;
`endif

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        rx_pin = 1'b1;
    logic        rx_out;
    logic        chip_reset;
    logic        break_active;
    logic [15:0] glitch_count;

    rx_line_conditioner #(
        .SYNC_STAGES        (S),
        .BREAK_CYCLES       (32'(B)),
        .RESET_PULSE_CYCLES (32'(R))
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_pin       (rx_pin),
        .rx_out       (rx_out),
        .chip_reset   (chip_reset),
        .break_active (break_active),
        .glitch_count (glitch_count)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: pin_hist[j] is the pin value sampled j edges ago (0 = this edge).
    bit pin_hist[8] = '{default: 1'b1};
    bit m_rx       = 1'b1;
    int m_gc       = 0;
    int pulse_left = R;
    bit armed      = 1'b0;
    int low_run    = 0;
    bit m_brk      = 1'b0;
    int cyc_n      = 0;

    always @(posedge clk) cyc_n++;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            foreach (pin_hist[i]) pin_hist[i] = 1'b1;
            m_rx = 1'b1; m_gc = 0; pulse_left = R;
            armed = 1'b0; low_run = 0; m_brk = 1'b0;
        end else begin
            // Break rules see the filtered line as it was during the closing cycle.
            if (pulse_left > 0) begin
                pulse_left--;
            end else if (!armed) begin
                if (m_rx) begin armed = 1'b1; m_brk = 1'b0; end
            end else begin
                low_run = m_rx ? 0 : low_run + 1;
                if (low_run == B) begin
                    pulse_left = R; m_brk = 1'b1; armed = 1'b0; low_run = 0;
                end
            end
            for (int i = 7; i > 0; i--) pin_hist[i] = pin_hist[i-1];
            pin_hist[0] = rx_pin;
            m_rx = (pin_hist[S+1] + pin_hist[S+2] + pin_hist[S+3]) >= 2;
            if (pin_hist[S+2] != pin_hist[S+1] && pin_hist[S+2] != pin_hist[S+3] && m_gc < 65535)
                m_gc++;
        end
    end

    int hi_cnt = 0, rise_cnt = 0, ba_cnt = 0, low_cnt = 0;
    int fall_cyc = 0, rise_cyc = 0, cr_rise_cyc = 0;
    bit prev_cr = 1'b1, prev_rx = 1'b1;

    always @(negedge clk) begin
        check("rx_out", rx_out, m_rx);
        check("chip_reset", chip_reset, (pulse_left > 0));
        check("break_active", break_active, m_brk);
        check("glitch_count", glitch_count, GC_ON ? m_gc : 0);
        if (reset) begin
            if (chip_reset) hi_cnt++;
            if (chip_reset && !prev_cr) begin rise_cnt++; cr_rise_cyc = cyc_n; end
            if (break_active) ba_cnt++;
            if (!rx_out) low_cnt++;
            if (!rx_out && prev_rx) fall_cyc = cyc_n;
            if (rx_out && !prev_rx) rise_cyc = cyc_n;
        end
        prev_cr = chip_reset;
        prev_rx = rx_out;
    end

    task automatic drive(input bit v, input int n);
        repeat (n) begin
            @(posedge clk);
            #1 rx_pin = v;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, r0, b0, l0, d0;
        bit found;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_out", rx_out, 1);
        check("rst_chip_reset", chip_reset, 1);
        check("rst_break", break_active, 0);
        check("rst_glitch", glitch_count, 0);
        reset = 1'b1;
        h0 = hi_cnt;
        drive(1, 12);
        check("por_width", hi_cnt - h0, R);

        // single-sample low is rejected and counted
        l0 = low_cnt;
        drive(0, 1);
        drive(1, 12);
        check("glitch_rx_low", low_cnt - l0, 0);
        check("glitch_cnt1", glitch_count, GC_ON);

        // two-sample low passes with 5-cycle latency
        @(posedge clk);
        #1 d0 = cyc_n; rx_pin = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rx_pin = 1'b1;
        drive(1, 12);
        check("pulse2_latency", fall_cyc - d0, 5);
        check("pulse2_width", rise_cyc - fall_cyc, 2);

        // seven low cycles: no break
        l0 = low_cnt; h0 = hi_cnt; b0 = ba_cnt;
        drive(0, 7);
        drive(1, 12);
        check("short_low_len", low_cnt - l0, 7);
        check("short_no_reset", hi_cnt - h0, 0);
        check("short_no_break", ba_cnt - b0, 0);

        // 30-cycle break: one 4-cycle pulse after the 8th low cycle
        h0 = hi_cnt; r0 = rise_cnt; b0 = ba_cnt;
        drive(0, 30);
        drive(1, 12);
        check("break_pulses", rise_cnt - r0, 1);
        check("break_width", hi_cnt - h0, R);
        check("break_delay", cr_rise_cyc - fall_cyc, B);
        check("break_active_len", ba_cnt - b0, 23);

        // pin 1,0,1 yields a single high rx_out cycle: two breaks
        r0 = rise_cnt;
        drive(0, 20); drive(1, 1); drive(0, 1); drive(1, 1); drive(0, 20);
        drive(1, 12);
        check("b2b_two_pulses", rise_cnt - r0, 2);

        // a lone high pin sample is filtered: still one break
        r0 = rise_cnt;
        drive(0, 20); drive(1, 1); drive(0, 20);
        drive(1, 12);
        check("b2b_one_pulse", rise_cnt - r0, 1);
        check("glitch_total", glitch_count, 5 * GC_ON);

        // reset in the second pulse cycle, then a fresh power-on pulse
        drive(0, 1);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (chip_reset) found = 1'b1;
        end
        check("midpulse_seen", found, 1);
        @(posedge clk);
        #1 reset = 1'b0; rx_pin = 1'b1;
        #1;
        check("mid_rst_chip_reset", chip_reset, 1);
        check("mid_rst_break", break_active, 0);
        check("mid_rst_rx_out", rx_out, 1);
        check("mid_rst_glitch", glitch_count, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        h0 = hi_cnt;
        drive(1, 12);
        check("repor_width", hi_cnt - h0, R);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rx_line_conditioner.md
# rx_line_conditioner

Front-end conditioner for the serial input pin. It feeds the chip top level's `uart_rx` and `chip_reset` inputs. It synchronises the asynchronous RX pin, removes single-sample glitches with a 3-tap majority filter, and detects a host "break" (line held low for a long time). A break produces a `chip_reset` pulse, which lets the host force a program reload over the same wire.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flops in the metastability chain; legal range ≥2.
- `BREAK_CYCLES`, 32'd20000: consecutive low cycles of the filtered line that make a break; legal range ≥2.
- `RESET_PULSE_CYCLES`, 32'd16: width of each `chip_reset` pulse; legal range ≥1.

Ports:
- `clk`  in  1  single clock domain.
- `reset`  in  1  asynchronous, active-low (0 = in reset).
- `rx_pin`  in  1  raw asynchronous serial line; idles high.
- `rx_out`  out  1  conditioned line, drives the chip's `uart_rx`.
- `chip_reset`  out  1  active-high reset request, drives the chip's `chip_reset`.
- `break_active`  out  1  high while the filtered line has been low ≥`BREAK_CYCLES` cycles and has not yet returned high.
- `glitch_count`  out  16  saturating count of rejected isolated samples.

## Operation
- Sync chain `sync[0..SYNC_STAGES-1]` resets to 1. `sync[0]` samples `rx_pin`.
- Window `w0,w1,w2` resets to 1. Each cycle: `w0<=sync[last]`, `w1<=w0`, `w2<=w1`.
- `rx_out` is registered: `rx_out <= majority(w0,w1,w2)`. Reset value is 1.
- Glitch event: `w1!=w0 && w1!=w2` (isolated middle sample). On each glitch event, `glitch_count` increments. It saturates at 16'hFFFF. Reset value is 0.
- FSM states:
  - `POR`: power-on pulse. On entry the internal counter is 0 and `chip_reset`=1. Count `RESET_PULSE_CYCLES` cycles, then go to `WAIT_HIGH`.
  - `IDLE`: if `rx_out`=0, go to `COUNT` with counter=1.
  - `COUNT`:
    - If `rx_out`=1, go to `IDLE`.
    - Else if counter==`BREAK_CYCLES`-1, go to `PULSE` with counter=0 and set `break_active`=1.
    - Else increment the counter.
  - `PULSE`: `chip_reset`=1 for `RESET_PULSE_CYCLES` cycles, then go to `WAIT_HIGH`.
  - `WAIT_HIGH`: if `rx_out`=1, go to `IDLE` and clear `break_active`.
- Reset values:
  - State is `POR`.
  - `chip_reset`=1, `break_active`=0, `rx_out`=1, `glitch_count`=0.
- A break that outlasts the pulse yields exactly one pulse. A new break requires `rx_out` high for ≥1 cycle first.
- Counter width is 32 bits. The counter never wraps, because `COUNT` exits before reaching `BREAK_CYCLES`.
- Asserting `reset` mid-pulse or mid-count immediately restores all reset values. The block then re-enters `POR` and emits a full power-on pulse.

## Timing
- Latency from an `rx_pin` edge to the matching `rx_out` edge is `SYNC_STAGES`+3 cycles (5 at default).
- A 1-cycle pin pulse never reaches `rx_out`. A ≥2-cycle pulse always does.
- `chip_reset` rises at the clock edge that ends the `BREAK_CYCLES`-th consecutive cycle with `rx_out`=0. It stays high for exactly `RESET_PULSE_CYCLES` cycles.
- `break_active` rises in the same cycle as `chip_reset`. It falls one edge after `rx_out` is seen high in `WAIT_HIGH`.
- After reset deassertion, `chip_reset` stays high for `RESET_PULSE_CYCLES` cycles.
- `glitch_count` updates one edge after the glitch window pattern appears.

## Configuration
- Macro `RX_COND_GLITCH_COUNT_EN`.
- Defined: the glitch detector and the 16-bit saturating counter are built, and `glitch_count` behaves as specified.
- Undefined: no counter logic is built, and `glitch_count` is tied to 16'h0000. All other behaviour is unchanged.

## Structure
- Package `rx_cond_pkg` holds:
  - the FSM state typedef `rx_cond_state_t` (`POR`, `IDLE`, `COUNT`, `PULSE`, `WAIT_HIGH`);
  - the 16-bit `glitch_count_t` typedef;
  - the `GLITCH_MAX` constant.
- Sub-module `rx_majority_filter`: the sync chain, the 3-sample window, the registered majority output, and the glitch-event strobe. The break FSM and counters live in the top module.

## Test plan
Bench parameters: `SYNC_STAGES`=2, `BREAK_CYCLES`=8, `RESET_PULSE_CYCLES`=4.
- Power-on: release `reset` with `rx_pin`=1 → `chip_reset`=1 for exactly 4 cycles, then 0; `rx_out` stays 1 throughout; `glitch_count`=0.
- Filtering: drive `rx_pin` low for 1 cycle → `rx_out` stays 1 and `glitch_count`=1. Then drive it low for 2 cycles → `rx_out` low for 2 cycles, starting 5 cycles after the pin edge.
- Short low: hold `rx_pin` low so `rx_out` is low for 7 cycles, then high → no `chip_reset`, `break_active` stays 0, FSM returns to `IDLE`.
- Break: hold `rx_out` low for 30 cycles → `chip_reset` high 4 cycles starting after the 8th low cycle. `break_active`=1 until 1 edge after `rx_out` returns high. Exactly one pulse.
- Back-to-back breaks: two breaks separated by `rx_out` high for 1 cycle → two pulses. With the separating 1-cycle pin pulse instead (filtered out) → one pulse.
- Reset mid-pulse: assert `reset`=0 during the 2nd pulse cycle → all outputs take reset values immediately. After release, a fresh 4-cycle `POR` pulse follows.
